// File: rtl/fetch_pipe_ctrl.sv
// Fetch-side pipeline control: owns PC and IF/ID, applies stall/flush/redirect, and
// polices the Stall/Flush protocol. Optional perf counters under FETCH_PERF_CNT_EN.
module fetch_pipe_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MAX_STALL = 8,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic [31:0] InstrIn,
    output logic [31:0] PC,
    output logic [31:0] IF_IDInstr,
    output logic [31:0] IF_IDPCPlus4,
    output logic        IF_IDValid,
    output logic        ID_EXBubble,
    output logic        StallTimeout,
    output logic        ProtoErr,
    output logic [1:0]  DbgState
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] StallCycles,
    output logic [31:0] FlushCount,
    output logic [31:0] RedirectCount
`endif
);

    // Handshake: Stall holds PC and IF/ID; Flush is only meaningful together with
    // Stall (it zeroes ID/EX this cycle); Flush without Stall is a protocol error
    // and is otherwise ignored. Redirects are accepted only when Stall is low.

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALLED  = 2'd1,
        REDIRECT = 2'd2
    } fetchState_t;

    fetchState_t state;
    fetchState_t nextState;

    logic [7:0]  stallCnt;
    logic [7:0]  stallCntNext;
    logic [31:0] pcPlus4;
    logic [31:0] redirectTarget;
    logic        takeRedirect;
    logic        timeoutHit;

    assign pcPlus4     = PC + 32'd4;
    assign ID_EXBubble = Stall & Flush & ~reset;
    assign DbgState    = state;

    always_comb begin
        nextState      = state;
        stallCntNext   = 8'd0;
        takeRedirect   = 1'b0;
        redirectTarget = JumpTarget;
        timeoutHit     = 1'b0;

        if (!Stall && (BranchTaken || Jump)) begin
            takeRedirect   = 1'b1;
            redirectTarget = BranchTaken ? BranchTarget : JumpTarget;
        end

        if (Stall) begin
            stallCntNext = (stallCnt == 8'hFF) ? stallCnt : stallCnt + 8'd1;
            // Counter holds completed stall cycles, so this edge completes cycle cnt+1.
            timeoutHit   = (32'(stallCnt) >= MAX_STALL);
        end

        case (state)
            RUN, STALLED, REDIRECT: begin
                if (Stall) begin
                    nextState = STALLED;
                end else if (takeRedirect) begin
                    nextState = REDIRECT;
                end else begin
                    nextState = RUN;
                end
            end
            default: nextState = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            stallCnt     <= 8'd0;
            PC           <= RESET_PC;
            IF_IDInstr   <= NOP_WORD;
            IF_IDPCPlus4 <= 32'd0;
            IF_IDValid   <= 1'b0;
            StallTimeout <= 1'b0;
            ProtoErr     <= 1'b0;
        end else begin
            state    <= nextState;
            stallCnt <= stallCntNext;
            if (timeoutHit) begin
                StallTimeout <= 1'b1;
            end
            if (Flush && !Stall) begin
                ProtoErr <= 1'b1;
            end
            if (!Stall) begin
                if (takeRedirect) begin
                    PC           <= redirectTarget;
                    IF_IDInstr   <= NOP_WORD;
                    IF_IDPCPlus4 <= 32'd0;
                    IF_IDValid   <= 1'b0;
                end else begin
                    PC           <= pcPlus4;
                    IF_IDInstr   <= InstrIn;
                    IF_IDPCPlus4 <= pcPlus4;
                    IF_IDValid   <= 1'b1;
                end
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            StallCycles   <= 32'd0;
            FlushCount    <= 32'd0;
            RedirectCount <= 32'd0;
        end else begin
            if (Stall) begin
                StallCycles <= StallCycles + 32'd1;
            end
            if (Stall && Flush) begin
                FlushCount <= FlushCount + 32'd1;
            end
            if (takeRedirect) begin
                RedirectCount <= RedirectCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// Bench for fetch_pipe_ctrl: directed walk through the main scenarios, then randomized
// traffic, all checked against a cycle-level behavioural model.
module tb_fetch_pipe_ctrl;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          MAX_STALL = 3;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall, Flush, BranchTaken, Jump;
    logic [31:0] BranchTarget, JumpTarget, InstrIn;
    logic [31:0] PC, IF_IDInstr, IF_IDPCPlus4;
    logic        IF_IDValid, ID_EXBubble, StallTimeout, ProtoErr;
    logic [1:0]  DbgState;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] StallCycles, FlushCount, RedirectCount;
`endif

    fetch_pipe_ctrl #(
        .RESET_PC (RESET_PC),
        .MAX_STALL(MAX_STALL),
        .NOP_WORD (NOP_WORD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Stall       (Stall),
        .Flush       (Flush),
        .BranchTaken (BranchTaken),
        .BranchTarget(BranchTarget),
        .Jump        (Jump),
        .JumpTarget  (JumpTarget),
        .InstrIn     (InstrIn),
        .PC          (PC),
        .IF_IDInstr  (IF_IDInstr),
        .IF_IDPCPlus4(IF_IDPCPlus4),
        .IF_IDValid  (IF_IDValid),
        .ID_EXBubble (ID_EXBubble),
        .StallTimeout(StallTimeout),
        .ProtoErr    (ProtoErr),
        .DbgState    (DbgState)
`ifdef FETCH_PERF_CNT_EN
        ,
        .StallCycles  (StallCycles),
        .FlushCount   (FlushCount),
        .RedirectCount(RedirectCount)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    // Behavioural model state
    logic [31:0] mPc, mInstr, mPc4;
    logic        mValid, mTimeout, mProto;
    logic [1:0]  mState;
    int          stallRun;
    logic [31:0] mStallCycles, mFlushCount, mRedirectCount;
    logic [31:0] expQ[$];

    int checks = 0;
    int errors = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance one edge, update model, compare outputs.
    task automatic cycle(input logic rst, input logic s, input logic f,
                         input logic bt, input logic [31:0] btgt,
                         input logic j, input logic [31:0] jtgt,
                         input logic [31:0] instr);
        logic [31:0] seqPc;
        reset = rst; Stall = s; Flush = f; BranchTaken = bt; BranchTarget = btgt;
        Jump = j; JumpTarget = jtgt; InstrIn = instr;
        @(negedge clk);
        checkVal("bubble", 32'(ID_EXBubble), 32'(s & f & ~rst));
        @(posedge clk);
        if (rst) begin
            mPc = RESET_PC; mInstr = NOP_WORD; mPc4 = 32'd0; mValid = 1'b0;
            mTimeout = 1'b0; mProto = 1'b0; stallRun = 0; mState = 2'd0;
            mStallCycles = 0; mFlushCount = 0; mRedirectCount = 0;
            expQ.delete();
        end else begin
            if (f && !s) mProto = 1'b1;
            if (s) begin
                stallRun++;
                if (stallRun > MAX_STALL) mTimeout = 1'b1;
                mStallCycles++;
                if (f) mFlushCount++;
                mState = 2'd1;
            end else begin
                stallRun = 0;
                if (bt || j) begin
                    mPc = bt ? btgt : jtgt;
                    mInstr = NOP_WORD; mPc4 = 32'd0; mValid = 1'b0;
                    mRedirectCount++;
                    mState = 2'd2;
                    expQ.push_back(mPc);
                end else begin
                    seqPc = mPc + 32'd4;
                    mPc = seqPc; mInstr = instr; mPc4 = seqPc; mValid = 1'b1;
                    mState = 2'd0;
                end
            end
        end
        #1;
        checkVal("pc", PC, mPc);
        checkVal("ifid_instr", IF_IDInstr, mInstr);
        checkVal("ifid_pc4", IF_IDPCPlus4, mPc4);
        checkVal("ifid_valid", 32'(IF_IDValid), 32'(mValid));
        checkVal("stall_timeout", 32'(StallTimeout), 32'(mTimeout));
        checkVal("proto_err", 32'(ProtoErr), 32'(mProto));
        checkVal("state", 32'(DbgState), 32'(mState));
        if (expQ.size() > 0) checkVal("redirect_pc", PC, expQ.pop_front());
`ifdef FETCH_PERF_CNT_EN
        checkVal("stall_cycles", StallCycles, mStallCycles);
        checkVal("flush_count", FlushCount, mFlushCount);
        checkVal("redirect_count", RedirectCount, mRedirectCount);
`endif
    endtask

    task automatic freeRun(input int n, input logic [31:0] instr);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 32'h0, 0, 32'h0, instr);
    endtask

    initial begin
        int burst;
        logic s, f, bt, j, rst;
        burst = 0;
        reset = 1'b1; Stall = 0; Flush = 0; BranchTaken = 0; Jump = 0;
        BranchTarget = 0; JumpTarget = 0; InstrIn = 0;
        @(posedge clk); #1;

        // Reset state
        cycle(1, 0, 0, 0, 0, 0, 0, 32'h0);
        cycle(1, 1, 1, 1, 32'h40, 1, 32'h80, 32'h1234_5678);
        // Sequential fetch to PC=8, then stall+flush twice, release
        freeRun(2, 32'h2008_0005);
        cycle(0, 1, 1, 0, 0, 0, 0, 32'hDEAD_BEEF);
        cycle(0, 1, 1, 0, 0, 0, 0, 32'hDEAD_BEEF);
        freeRun(2, 32'h2008_0005);
        // Branch under stall is ignored, then accepted
        cycle(0, 1, 0, 1, 32'h40, 0, 0, 32'h1111_1111);
        cycle(0, 0, 0, 1, 32'h40, 0, 0, 32'h1111_1111);
        freeRun(2, 32'h2222_2222);
        // Branch beats jump; back-to-back redirects
        cycle(0, 0, 0, 1, 32'h100, 1, 32'h200, 32'h3333_3333);
        cycle(0, 0, 0, 0, 32'h0, 1, 32'h200, 32'h3333_3333);
        // Wrap from the top of the address space
        cycle(0, 0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC, 32'h0);
        freeRun(2, 32'h4444_4444);
        // MAX_STALL stalls are legal; one more sets the sticky timeout
        for (int i = 0; i < MAX_STALL; i++) cycle(0, 1, 0, 0, 0, 0, 0, 32'h0);
        freeRun(1, 32'h5555_5555);
        for (int i = 0; i < MAX_STALL + 1; i++) cycle(0, 1, 0, 0, 0, 0, 0, 32'h0);
        freeRun(3, 32'h5555_5555);
        // Flush without Stall
        cycle(0, 0, 1, 0, 0, 0, 0, 32'h6666_6666);
        freeRun(2, 32'h6666_6666);
        // Reset mid-stall
        cycle(0, 1, 0, 0, 0, 0, 0, 32'h0);
        cycle(1, 1, 0, 0, 0, 0, 0, 32'h0);
        freeRun(1, 32'h7777_7777);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (burst > 0) begin
                s = 1'b1; burst--;
            end else if ($urandom_range(0, 9) == 0) begin
                s = 1'b1; burst = $urandom_range(0, 5);
            end else begin
                s = 1'b0;
            end
            f  = s ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 49) == 0);
            bt = ($urandom_range(0, 5) == 0);
            j  = ($urandom_range(0, 5) == 0);
            cycle(rst, s, f, bt, {$urandom(), 2'b00} >> 0 & 32'hFFFF_FFFC, j,
                  $urandom() & 32'hFFFF_FFFC, $urandom());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
